// File: rtl/arith_pipe_pkg.sv
// Shared types and constants for the handshaked arithmetic/reduction unit.
package arith_pipe_pkg;

    // Op-codes on in_op; values 5..7 are reserved and raise the err flag.
    typedef enum logic [2:0] {
        OP_ADD3 = 3'd0,
        OP_SUB3 = 3'd1,
        OP_MULU = 3'd2,
        OP_MULS = 3'd3,
        OP_CMP  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StHold = 2'd2
    } state_e;

    // Bit positions inside out_flags.
    localparam int unsigned FLG_EQ      = 0;
    localparam int unsigned FLG_OR_AND  = 1;
    localparam int unsigned FLG_XOR_AND = 2;
    localparam int unsigned FLG_AND_OR  = 3;
    localparam int unsigned FLG_XNOR_OR = 4;
    localparam int unsigned FLG_ERR     = 5;
    localparam int unsigned NUM_FLAGS   = 6;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULU) || (op == OP_MULS);
    endfunction

endpackage

// File: rtl/arith_pipe_mul_iter.sv
// Digit-serial shift-add multiplier: loads magnitudes on start_i, consumes
// MUL_DIGIT multiplier bits per step_i cycle (LSB first) and applies the sign
// on the last step, where done_o is raised together with a valid product_o.
module arith_pipe_mul_iter
    import arith_pipe_pkg::*;
#(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned MUL_DIGIT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               neg_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned N    = WIDTH / MUL_DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               neg_q, neg_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_sum;
    logic               last;

    // One iteration: add the shifted multiplicand for each set bit of the digit.
    always_comb begin
        partial = '0;
        for (int unsigned j = 0; j < MUL_DIGIT; j++) begin
            if (b_sh_q[j]) begin
                partial = partial + (a_sh_q << j);
            end
        end
        acc_sum   = acc_q + partial;
        last      = (cnt_q == CntW'(N - 1));
        done_o    = step_i && last;
        product_o = neg_q ? -acc_sum : acc_sum;
    end

    // Next-state for the operand shifters, accumulator and iteration counter.
    always_comb begin
        acc_d  = acc_q;
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        neg_d  = neg_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            acc_d  = '0;
            a_sh_d = {{WIDTH{1'b0}}, a_i};
            b_sh_d = b_i;
            neg_d  = neg_i;
            cnt_d  = '0;
        end else if (step_i) begin
            acc_d  = acc_sum;
            a_sh_d = a_sh_q << MUL_DIGIT;
            b_sh_d = b_sh_q >> MUL_DIGIT;
            cnt_d  = last ? '0 : cnt_q + CntW'(1);
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            a_sh_q <= '0;
            b_sh_q <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/arith_pipe_unit.sv
// Handshaked arithmetic/reduction unit: one op in flight, registered result,
// single-cycle ADD3/SUB3/CMP and an iterative multiplier for MULU/MULS.
module arith_pipe_unit
    import arith_pipe_pkg::*;
#(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned MUL_DIGIT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH-1:0]   in_c,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic [5:0]         out_flags
);

    if (WIDTH < 8 || MUL_DIGIT == 0 || (WIDTH % MUL_DIGIT) != 0) begin : g_param_check
        $error("arith_pipe_unit: WIDTH must be >= 8 and a multiple of MUL_DIGIT");
    end

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   out_result_q, out_result_d;
    logic [NUM_FLAGS-1:0] out_flags_q, out_flags_d;
    logic [NUM_FLAGS-1:0] flags_pend_q, flags_pend_d;

    logic                 accept;
    logic                 is_mul;
    logic [NUM_FLAGS-1:0] flags_now;
    logic [WIDTH+1:0]     sum3;
    logic [WIDTH+1:0]     diff3;
    logic [2*WIDTH-1:0]   single_res;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    // Handshake; rst_n gating keeps operands out while the unit is held in reset.
    always_comb begin
        in_ready  = rst_n && ((state_q == StIdle) || ((state_q == StHold) && out_ready));
        accept    = in_valid && in_ready;
        is_mul    = is_mul_op(in_op);
        out_valid = (state_q == StHold);
    end

    // Flags, single-cycle results and multiplier magnitudes from the live operands.
    always_comb begin
        flags_now              = '0;
        flags_now[FLG_EQ]      = (in_a == in_b);
        flags_now[FLG_OR_AND]  = |(in_a & in_b & in_c);
        flags_now[FLG_XOR_AND] = ^(in_a & in_b & in_c);
        flags_now[FLG_AND_OR]  = &(in_a | in_b | in_c);
        flags_now[FLG_XNOR_OR] = ~^(in_a | in_b | in_c);
        flags_now[FLG_ERR]     = (in_op > OP_CMP);

        sum3  = {2'b00, in_a} + {2'b00, in_b} + {2'b00, in_c};
        diff3 = {2'b00, in_a} - {2'b00, in_b} - {2'b00, in_c};
        single_res = '0;
        if (in_op == OP_ADD3) begin
            single_res = {{(WIDTH - 2){1'b0}}, sum3};
        end else if (in_op == OP_SUB3) begin
            single_res = {{(WIDTH - 2){diff3[WIDTH+1]}}, diff3};
        end

        a_neg = (in_op == OP_MULS) && in_a[WIDTH-1];
        b_neg = (in_op == OP_MULS) && in_b[WIDTH-1];
        a_mag = a_neg ? -in_a : in_a;
        b_mag = b_neg ? -in_b : in_b;
    end

    arith_pipe_mul_iter #(
        .WIDTH     (WIDTH),
        .MUL_DIGIT (MUL_DIGIT)
    ) u_mul_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept && is_mul),
        .step_i    (state_q == StMul),
        .a_i       (a_mag),
        .b_i       (b_mag),
        .neg_i     (a_neg ^ b_neg),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // FSM next-state; result registers only load on entry to StHold.
    always_comb begin
        state_d      = state_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        flags_pend_d = flags_pend_q;
        unique case (state_q)
            StIdle, StHold: begin
                if ((state_q == StHold) && out_ready) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    if (is_mul) begin
                        state_d      = StMul;
                        flags_pend_d = flags_now;
                    end else begin
                        state_d      = StHold;
                        out_result_d = single_res;
                        out_flags_d  = flags_now;
                    end
                end
            end
            StMul: begin
                if (mul_done) begin
                    state_d      = StHold;
                    out_result_d = mul_product;
                    out_flags_d  = flags_pend_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            out_result_q <= '0;
            out_flags_q  <= '0;
            flags_pend_q <= '0;
        end else begin
            state_q      <= state_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            flags_pend_q <= flags_pend_d;
        end
    end

    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule
